// File: rtl/rand_range_fifo.sv
// Turns a free-running 16-bit random word into unbiased values in [0, RANGE)
// by rejection sampling, and buffers them in a small first-word-fall-through FIFO.
module rand_range_fifo #(
    parameter int RANGE      = 9,
    parameter int OUT_W      = 4,
    parameter int DEPTH      = 4,
    parameter int NO_REPEAT  = 1,
    parameter int MAX_REJECT = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [15:0]              rand_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     forced
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [15:0]      RANGE_W = 16'(RANGE);
    localparam logic [15:0]      LIMIT_W = 16'(32768 - (32768 % RANGE));
    localparam logic [OUT_W-1:0] TOP_VAL = OUT_W'(RANGE - 1);
    localparam logic [7:0]       MAX_REJ = 8'(MAX_REJECT);
    localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);

    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic [OUT_W-1:0] head_reg;
    logic [7:0]       rej_cnt_reg;
    logic             has_last_reg;
    logic [OUT_W-1:0] last_val_reg;
    logic             forced_reg;

    logic [15:0]      s_ext, cand_w;
    logic [OUT_W-1:0] cand, force_val, push_val;
    logic [AW-1:0]    rd_ptr_inc;
    logic             pop, eligible, reject, force_now, push;
    logic             unused_bits;

    assign s_ext       = {1'b0, rand_in[14:0]};
    assign cand_w      = s_ext % RANGE_W;
    assign cand        = cand_w[OUT_W-1:0];
    assign unused_bits = ^{rand_in[15], cand_w[15:OUT_W]};

    assign pop       = out_valid & out_ready;
    assign eligible  = en & ((level_reg < DEPTH_L) | pop);
    assign reject    = (s_ext >= LIMIT_W) |
                       ((NO_REPEAT != 0) & has_last_reg & (cand == last_val_reg));
    assign force_now = eligible & reject & (rej_cnt_reg == MAX_REJ);
    assign push      = eligible & (~reject | force_now);
    assign force_val = !has_last_reg ? '0 :
                       (last_val_reg == TOP_VAL) ? '0 : last_val_reg + 1'b1;
    assign push_val  = force_now ? force_val : cand;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    // Storage has no reset; only the control state and the head register do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            head_reg     <= '0;
            rej_cnt_reg  <= '0;
            has_last_reg <= 1'b0;
            last_val_reg <= '0;
            forced_reg   <= 1'b0;
        end else begin
            forced_reg <= force_now;
            if (eligible) begin
                rej_cnt_reg <= push ? 8'd0 : rej_cnt_reg + 8'd1;
            end
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                last_val_reg <= push_val;
                has_last_reg <= 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            // Head is kept registered so it simply holds once the FIFO empties.
            if (pop) begin
                if (level_reg > LW'(1)) begin
                    head_reg <= mem[rd_ptr_inc];
                end else if (push) begin
                    head_reg <= push_val;
                end
            end else if ((level_reg == '0) && push) begin
                head_reg <= push_val;
            end
        end
    end

    assign out_valid  = (level_reg != '0);
    assign out_data   = head_reg;
    assign fifo_level = level_reg;
    assign forced     = forced_reg;

endmodule

// File: doc/rand_range_fifo.md
Name: rand_range_fifo

Overview:
- Consumes the 16-bit pseudo-random word produced each clock by the upstream random generator.
- Reduces each word to an unbiased integer in [0, RANGE) by rejection sampling.
- Optionally suppresses immediate repeats of the previous value.
- Buffers accepted values in a small first-word-fall-through FIFO with valid/ready output, so game logic (e.g. target-cell selection) can pull bounded random values on demand.

Parameters:
- RANGE, 9: number of output values; legal 2..256.
- OUT_W, 4: output width; must satisfy 2^OUT_W >= RANGE.
- DEPTH, 4: FIFO entries; power of two, 2..16.
- NO_REPEAT, 1: when 1, a value equal to the last pushed value is rejected.
- MAX_REJECT, 7: consecutive rejections tolerated before a forced accept; range 1..255.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  sampling enable; 0 freezes sampling, while output pops remain allowed.
- rand_in  in  16  upstream random word; only bits [14:0] are used, bit 15 is ignored.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_valid  out  1  FIFO non-empty.
- out_data  out  OUT_W  head-of-FIFO value, 0..RANGE-1.
- fifo_level  out  $clog2(DEPTH)+1  number of stored entries.
- forced  out  1  one-cycle pulse on the edge that pushed a forced value.

Behaviour:
- Reset (async, any time including mid-pop): FIFO empty; out_valid=0, out_data=0, fifo_level=0, forced=0; rej_cnt=0; has_last=0, last_val=0.
- Constants:
  - s = rand_in[14:0].
  - LIMIT = 32768 - (32768 mod RANGE). For RANGE=9, LIMIT=32760.
  - cand = s mod RANGE, computed combinationally from the current-cycle rand_in; no input register.
- pop = out_valid & out_ready.
- Eligible cycle: en=1 and (fifo_level < DEPTH, or pop=1).
  - Full with simultaneous pop is a legal push.
  - Full without pop: no sampling; rej_cnt holds.
- Reject condition on an eligible cycle: s >= LIMIT, or (NO_REPEAT=1 and has_last=1 and cand == last_val).
- Per eligible cycle:
  - Not rejected: push cand; rej_cnt <= 0.
  - Rejected and rej_cnt < MAX_REJECT: no push; rej_cnt <= rej_cnt+1.
  - Rejected and rej_cnt == MAX_REJECT: push forced value f; rej_cnt <= 0; forced=1 for that cycle.
    - f = (last_val+1) mod RANGE if has_last=1, else 0.
- On every push: last_val <= pushed value; has_last <= 1.
- Non-eligible cycles: no push, no rej_cnt change, forced=0.
- FIFO:
  - First-word-fall-through; out_data shows the head whenever out_valid=1.
  - out_data holds its last value when empty; it is undefined to the consumer.
  - Write/read pointers wrap modulo DEPTH.
  - Simultaneous push and pop: level unchanged, head advances.
  - Pop while empty is ignored.
- Latency: a value pushed at edge k is visible on out_data/out_valid after edge k when the FIFO was empty (one cycle from rand_in to output).
- fifo_level and out_valid are registered-consistent: both update on the same edge.
- en=0 with a non-empty FIFO: entries drain normally via out_ready.
- Ordering: values leave in push order; no reordering, no duplication, no loss when out_ready honours out_valid.

Test Plan:
1. Reset/basic push:
   - Stimulus: assert rst mid-run; release; RANGE=9, en=1, rand_in=16'h0013 (s=19), out_ready=0.
   - Required: during rst all outputs 0. After 1 edge out_valid=1, out_data=1, fifo_level=1.
2. Boundary and repeat rejection:
   - Stimulus: rand_in=32760, then 32759, then 16'hFFFF.
   - Required: 32760 rejected (no push). 32759 pushes 8 (32759 mod 9). 16'hFFFF (s=32767) rejected.
   - Then rand_in=17, giving cand 8 == last_val: rejected when NO_REPEAT=1.
3. Forced accept:
   - Stimulus: last_val=3, rand_in held at 32765 for 8 eligible cycles.
   - Required: first 7 cycles no push. On the 8th cycle, push 4 with forced=1 for exactly 1 cycle; rej_cnt returns to 0.
4. Full FIFO:
   - Stimulus: fill to fifo_level=4 with out_ready=0, then apply a valid sample.
   - Required: no push, level stays 4, rej_cnt unchanged.
   - Then out_ready=1 with a valid sample: head pops and the new value pushes in the same cycle; level stays 4; output order preserved.
5. Drain with en=0:
   - Stimulus: 3 entries stored, en=0, out_ready=1 for 4 cycles.
   - Required: entries emerge in push order on 3 consecutive cycles; level goes 3→2→1→0; out_valid=0 on the 4th cycle; no pushes occur.
6. Random soak:
   - Stimulus: 20,000 cycles, LCG-driven rand_in, random out_ready and en.
   - Required: all outputs < 9; no two consecutive pushed values equal; scoreboard order matches; every value 0..8 observed.
